// File: rtl/dram_byte_port.sv
// Byte-wide request front end for the 64Kx4 DRAM controller: queues byte requests and
// issues each as two nibble accesses (low nibble first), reassembling read bytes.
module dram_byte_port #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        idle,
    output logic [15:0] ctl_addr,
    output logic        ctl_write,
    output logic        ctl_ena,
    output logic [3:0]  ctl_wr_data,
    input  logic        ctl_busy,
    input  logic [3:0]  ctl_rd_data
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        write;
        logic [14:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ISSUE, S_WAIT, S_RESP} state_t;

    req_t             mem_q [FIFO_DEPTH];
    req_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             cur_write_q, cur_write_d;
    logic [14:0]      cur_addr_q, cur_addr_d;
    logic [3:0]       cur_hi_q, cur_hi_d;
    logic             nib_q, nib_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [15:0]      ctl_addr_q, ctl_addr_d;
    logic             ctl_write_q, ctl_write_d;
    logic             ctl_ena_q, ctl_ena_d;
    logic [3:0]       ctl_wr_data_q, ctl_wr_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;

    logic full, empty, push, pop;
    req_t head;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = req_valid && !full;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign head      = mem_q[rd_ptr_q];
    assign req_ready = !full;
    assign idle      = (state_q == S_IDLE) && empty;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign ctl_addr    = ctl_addr_q;
    assign ctl_write   = ctl_write_q;
    assign ctl_ena     = ctl_ena_q;
    assign ctl_wr_data = ctl_wr_data_q;

    // Request queue bookkeeping
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{write: req_write, addr: req_addr, wdata: req_wdata};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Nibble sequencer on the controller ena/busy handshake
    always_comb begin
        state_d       = state_q;
        cur_write_d   = cur_write_q;
        cur_addr_d    = cur_addr_q;
        cur_hi_d      = cur_hi_q;
        nib_d         = nib_q;
        rdata_d       = rdata_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_write_d   = ctl_write_q;
        ctl_ena_d     = ctl_ena_q;
        ctl_wr_data_d = ctl_wr_data_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    cur_write_d   = head.write;
                    cur_addr_d    = head.addr;
                    cur_hi_d      = head.wdata[7:4];
                    nib_d         = 1'b0;
                    ctl_addr_d    = {head.addr, 1'b0};
                    ctl_write_d   = head.write;
                    ctl_wr_data_d = head.wdata[3:0];
                    state_d       = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!ctl_busy) begin
                    ctl_ena_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ctl_busy) begin
                    ctl_ena_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ctl_busy) begin
                    if (!cur_write_q) begin
                        if (nib_q) rdata_d[7:4] = ctl_rd_data;
                        else       rdata_d[3:0] = ctl_rd_data;
                    end
                    if (!nib_q) begin
                        nib_d         = 1'b1;
                        ctl_addr_d    = {cur_addr_q, 1'b1};
                        ctl_wr_data_d = cur_hi_q;
                        state_d       = S_SYNC;
                    end else if (cur_write_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            cur_write_q   <= 1'b0;
            cur_addr_q    <= '0;
            cur_hi_q      <= '0;
            nib_q         <= 1'b0;
            rdata_q       <= '0;
            ctl_addr_q    <= '0;
            ctl_write_q   <= 1'b0;
            ctl_ena_q     <= 1'b0;
            ctl_wr_data_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            cur_write_q   <= cur_write_d;
            cur_addr_q    <= cur_addr_d;
            cur_hi_q      <= cur_hi_d;
            nib_q         <= nib_d;
            rdata_q       <= rdata_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_write_q   <= ctl_write_d;
            ctl_ena_q     <= ctl_ena_d;
            ctl_wr_data_q <= ctl_wr_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

endmodule
